alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  Single-cycle MIPS-subset execute unit. Decodes a 32-bit instruction, selects operands from two
//  register values, and produces the result, flags, HI/LO and datapath control signals.
//  Owns the PC and HI/LO registers. Sits between register-file read and writeback.
// PARAMETERS
//  RESET_PC  32'h0  PC value loaded on reset
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  i_datain   in   32  instruction
//  gr1        in   32  rs register value
//  gr2        in   32  rt register value
//  out        out  32  ALU result, combinational
//  hi, lo     out  32  HI/LO registers
//  zero       out  1   out==0
//  overflow   out  1   signed overflow (add/sub/addi only)
//  neg        out  1   out[31]
//  pc_src     out  1   branch taken
//  mem_write  out  1   sw
//  reg_write  out  1   instruction writes a GPR
//  reg_dst    out  1   1=rd (R-type), 0=rt
//  mem_to_reg out  1   lw
//  alu_ctrl   out  4   internal op code (encoding free, documented in RTL)
//  pc         out  32  current PC register
// BEHAVIOUR
//  - opcode=i_datain[31:26], funct=[5:0], shamt=[10:6], imm=[15:0]. srcA=gr1; srcB=gr2 for R-type/branch, else extended imm.
//  - R (op 0): add20 addu21 sub22 subu23 and24 or25 xor26 nor27 slt2A sltu2B; sll00 srl02 sra03 shift gr2 by shamt;
//    sllv04 srlv06 srav07 shift gr2 by gr1[4:0]; mult18 multu19 div1A divu1B write HI/LO only (out=0, reg_write=0).
//  - I: beq04 bne05 addi08 addiu09 slti0A sltiu0B (sign-ext imm); andi0C ori0D xori0E (zero-ext imm); lw23 sw2B out=gr1+sext(imm).
//  - slt/sltu/slti/sltiu: out=32'd1 or 0 (signed/unsigned compare). beq/bne: out=gr1-gr2; pc_src=zero (beq) / !zero (bne).
//  - overflow: add/addi/sub only, signed rule (same-sign operands, differing result sign); unsigned ops and others -> 0.
//    Result is still driven on out when overflow=1.
//  - Unsupported opcode/funct: out=0, all flags and controls 0, HI/LO unchanged.
//  - HI/LO register on rising clk: mult/multu {hi,lo}=64-bit product; div/divu lo=quotient, hi=remainder
//    (signed: truncate toward zero, remainder takes dividend sign). Divisor 0: hi=gr1, lo=32'hFFFF_FFFF.
//  - PC on rising clk: pc_src ? pc+4+(sext(imm)<<2) : pc+4, mod 2^32 wrap.
//  - Reset (async, rst_n=0): pc=RESET_PC, hi=lo=0; combinational outputs follow inputs regardless of reset.
// CONFIGURATION
//  ALU_DIVIDER_EN defined: div/divu implemented as above (combinational divider).
//  Not defined: div/divu decode as unsupported (HI/LO unchanged, all controls 0).
// TESTING
//  gr1=89999999 gr2=5DDDDDDD add(014B4820) -> out=E7777776 overflow=0 neg=1 reg_dst=1 reg_write=1
//  same operands sub(014B4822) -> out=2BBBBBBC overflow=1; subu -> same out, overflow=0
//  addi imm 8000 -> out=89991999 overflow=0; andi imm 0064 -> out=00000000 zero=1
//  sll gr2 shamt=1 -> BBBBBBBA; sra shamt=10 -> 0017_7777; sllv by gr1[4:0]=25 -> BA000000
//  mult gr1=FFFFFFFE gr2=3 -> after clk hi=FFFFFFFF lo=FFFFFFFA; divu 7/0 (ALU_DIVIDER_EN) -> hi=7 lo=FFFFFFFF
//  reset, then beq gr1==gr2 imm=FFFF -> pc_src=1, pc 0->0 after clk; bne same -> pc 0->4; rst_n low mid-run -> pc=0 at once

Source files
------------

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle MIPS-subset execute unit with PC and HI/LO registers
// Define ALU_DIVIDER_EN to implement div/divu; otherwise they decode as unsupported.
module alu_core #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_datain,
    input  logic [31:0] gr1,
    input  logic [31:0] gr2,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        zero,
    output logic        overflow,
    output logic        neg,
    output logic        pc_src,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] pc
);
    // alu_ctrl: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 slt, 8 sltu,
    //           9 sll, A srl, B sra, C mult, D multu, E div, F divu
    localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_NOR  = 4'h6, OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SLTU = 4'h8, OP_SLL  = 4'h9, OP_SRL  = 4'hA, OP_SRA  = 4'hB;
    localparam logic [3:0] OP_MULT = 4'hC, OP_MULTU = 4'hD, OP_DIV = 4'hE, OP_DIVU = 4'hF;
    localparam logic [1:0] B_RT = 2'd0, B_SEXT = 2'd1, B_ZEXT = 2'd2;

    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, sh_amt;
    logic [15:0] imm;
    logic [31:0] sext_imm, zext_imm, src_b, sum, diff, result;
    logic [3:0]  ctrl;
    logic [1:0]  b_sel;
    logic        valid, ovf_en, shift_var, is_beq, is_bne, rw, rd, mw, m2r;
    logic [63:0] prod_s, prod_u;
    logic [31:0] pc_d, pc_q, hi_d, hi_q, lo_d, lo_q;
    logic        unused_fields;

    assign opcode        = i_datain[31:26];
    assign funct         = i_datain[5:0];
    assign shamt         = i_datain[10:6];
    assign imm           = i_datain[15:0];
    assign sext_imm      = {{16{imm[15]}}, imm};
    assign zext_imm      = {16'h0, imm};
    assign unused_fields = &{1'b0, i_datain[25:16]};

    always_comb begin
        ctrl = OP_NOP; b_sel = B_RT; shift_var = 1'b0; ovf_en = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; rw = 1'b0; rd = 1'b0; mw = 1'b0; m2r = 1'b0;
        valid = 1'b0;
        if (opcode == 6'h00) begin
            valid = 1'b1; rd = 1'b1; rw = 1'b1;
            case (funct)
                6'h20: begin ctrl = OP_ADD; ovf_en = 1'b1; end
                6'h21: ctrl = OP_ADD;
                6'h22: begin ctrl = OP_SUB; ovf_en = 1'b1; end
                6'h23: ctrl = OP_SUB;
                6'h24: ctrl = OP_AND;
                6'h25: ctrl = OP_OR;
                6'h26: ctrl = OP_XOR;
                6'h27: ctrl = OP_NOR;
                6'h2A: ctrl = OP_SLT;
                6'h2B: ctrl = OP_SLTU;
                6'h00: ctrl = OP_SLL;
                6'h02: ctrl = OP_SRL;
                6'h03: ctrl = OP_SRA;
                6'h04: begin ctrl = OP_SLL; shift_var = 1'b1; end
                6'h06: begin ctrl = OP_SRL; shift_var = 1'b1; end
                6'h07: begin ctrl = OP_SRA; shift_var = 1'b1; end
                6'h18: begin ctrl = OP_MULT;  rw = 1'b0; end
                6'h19: begin ctrl = OP_MULTU; rw = 1'b0; end
`ifdef ALU_DIVIDER_EN
                6'h1A: begin ctrl = OP_DIV;  rw = 1'b0; end
                6'h1B: begin ctrl = OP_DIVU; rw = 1'b0; end
`endif
                default: begin valid = 1'b0; rd = 1'b0; rw = 1'b0; end
            endcase
        end else begin
            valid = 1'b1;
            case (opcode)
                6'h04: begin ctrl = OP_SUB; is_beq = 1'b1; end
                6'h05: begin ctrl = OP_SUB; is_bne = 1'b1; end
                6'h08: begin ctrl = OP_ADD;  b_sel = B_SEXT; ovf_en = 1'b1; rw = 1'b1; end
                6'h09: begin ctrl = OP_ADD;  b_sel = B_SEXT; rw = 1'b1; end
                6'h0A: begin ctrl = OP_SLT;  b_sel = B_SEXT; rw = 1'b1; end
                6'h0B: begin ctrl = OP_SLTU; b_sel = B_SEXT; rw = 1'b1; end
                6'h0C: begin ctrl = OP_AND;  b_sel = B_ZEXT; rw = 1'b1; end
                6'h0D: begin ctrl = OP_OR;   b_sel = B_ZEXT; rw = 1'b1; end
                6'h0E: begin ctrl = OP_XOR;  b_sel = B_ZEXT; rw = 1'b1; end
                6'h23: begin ctrl = OP_ADD;  b_sel = B_SEXT; rw = 1'b1; m2r = 1'b1; end
                6'h2B: begin ctrl = OP_ADD;  b_sel = B_SEXT; mw = 1'b1; end
                default: valid = 1'b0;
            endcase
        end
    end

    assign src_b  = (b_sel == B_SEXT) ? sext_imm : (b_sel == B_ZEXT) ? zext_imm : gr2;
    assign sh_amt = shift_var ? gr1[4:0] : shamt;
    assign sum    = gr1 + src_b;
    assign diff   = gr1 - src_b;

    always_comb begin
        result = 32'h0;
        case (ctrl)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_AND:  result = gr1 & src_b;
            OP_OR:   result = gr1 | src_b;
            OP_XOR:  result = gr1 ^ src_b;
            OP_NOR:  result = ~(gr1 | src_b);
            OP_SLT:  result = {31'h0, $signed(gr1) < $signed(src_b)};
            OP_SLTU: result = {31'h0, gr1 < src_b};
            OP_SLL:  result = gr2 << sh_amt;
            OP_SRL:  result = gr2 >> sh_amt;
            OP_SRA:  result = $unsigned($signed(gr2) >>> sh_amt);
            OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: result = 32'h0;
            default: result = 32'h0;
        endcase
    end

    assign out        = result;
    assign zero       = valid & (result == 32'h0);
    assign neg        = result[31];
    assign overflow   = ovf_en & ((ctrl == OP_ADD) ? (gr1[31] == src_b[31]) && (sum[31] != gr1[31])
                                                   : (gr1[31] != src_b[31]) && (diff[31] != gr1[31]));
    assign pc_src     = (is_beq & zero) | (is_bne & ~zero);
    assign mem_write  = mw;
    assign reg_write  = rw;
    assign reg_dst    = rd;
    assign mem_to_reg = m2r;
    assign alu_ctrl   = ctrl;

    assign prod_s = $signed({{32{gr1[31]}}, gr1}) * $signed({{32{gr2[31]}}, gr2});
    assign prod_u = {32'h0, gr1} * {32'h0, gr2};
`ifdef ALU_DIVIDER_EN
    logic signed [31:0] quot_s, rem_s;
    assign quot_s = $signed(gr1) / $signed(gr2);
    assign rem_s  = $signed(gr1) % $signed(gr2);
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (ctrl)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef ALU_DIVIDER_EN
            // A zero divisor leaves the dividend in HI and all-ones in LO.
            OP_DIV:  begin
                hi_d = (gr2 == 32'h0) ? gr1 : $unsigned(rem_s);
                lo_d = (gr2 == 32'h0) ? 32'hFFFF_FFFF : $unsigned(quot_s);
            end
            OP_DIVU: begin
                hi_d = (gr2 == 32'h0) ? gr1 : gr1 % gr2;
                lo_d = (gr2 == 32'h0) ? 32'hFFFF_FFFF : gr1 / gr2;
            end
`endif
            default: ;
        endcase
    end

    assign pc_d = pc_q + 32'd4 + (pc_src ? {{14{imm[15]}}, imm, 2'b00} : 32'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign pc = pc_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core against an arithmetic reference model
module tb_alu_core;
    logic        clk = 1'b0, rst_n;
    logic [31:0] i_datain, gr1, gr2, out, hi, lo, pc;
    logic        zero, overflow, neg, pc_src, mem_write, reg_write, reg_dst, mem_to_reg;
    logic [3:0]  alu_ctrl;
    int tests = 0, fails = 0;

    typedef struct packed {
        logic [31:0] out;
        logic ovf, rw, rd, mw, m2r, valid, taken, hl_we;
        logic [63:0] hl;
    } exp_t;

    always #5 clk = ~clk;

    alu_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .i_datain(i_datain), .gr1(gr1), .gr2(gr2),
        .out(out), .hi(hi), .lo(lo), .zero(zero), .overflow(overflow), .neg(neg),
        .pc_src(pc_src), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_ctrl(alu_ctrl), .pc(pc)
    );

    function automatic logic fits32(input longint r);
        longint lim = 64'sd2147483648;
        return (r >= -lim) && (r < lim);
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, si, r;
        logic [31:0] simm, zimm;
        logic [63:0] pu;
        int sh, shv;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        simm = {{16{ins[15]}}, ins[15:0]}; zimm = {16'h0, ins[15:0]};
        si = longint'($signed(simm));
        sh = int'(ins[10:6]); shv = int'(a[4:0]);
        e = '0;
        if (ins[31:26] == 6'h00) begin
            e.valid = 1'b1; e.rd = 1'b1; e.rw = 1'b1;
            case (ins[5:0])
                6'h20: begin r = sa + sb; e.out = r[31:0]; e.ovf = !fits32(r); end
                6'h21: e.out = a + b;
                6'h22: begin r = sa - sb; e.out = r[31:0]; e.ovf = !fits32(r); end
                6'h23: e.out = a - b;
                6'h24: e.out = a & b;
                6'h25: e.out = a | b;
                6'h26: e.out = a ^ b;
                6'h27: e.out = ~(a | b);
                6'h2A: e.out = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: e.out = (a < b) ? 32'd1 : 32'd0;
                6'h00: e.out = b << sh;
                6'h02: e.out = b >> sh;
                6'h03: begin r = sb >>> sh; e.out = r[31:0]; end
                6'h04: e.out = b << shv;
                6'h06: e.out = b >> shv;
                6'h07: begin r = sb >>> shv; e.out = r[31:0]; end
                6'h18: begin e.rw = 1'b0; e.hl_we = 1'b1; r = sa * sb; e.hl = r; end
                6'h19: begin e.rw = 1'b0; e.hl_we = 1'b1; pu = {32'h0, a} * {32'h0, b}; e.hl = pu; end
`ifdef ALU_DIVIDER_EN
                6'h1A, 6'h1B: begin
                    longint q, rm;
                    e.rw = 1'b0; e.hl_we = 1'b1;
                    if (b == 32'h0) e.hl = {a, 32'hFFFF_FFFF};
                    else begin
                        if (ins[0]) begin q = longint'(a) / longint'(b); rm = longint'(a) % longint'(b); end
                        else begin q = sa / sb; rm = sa % sb; end
                        e.hl = {rm[31:0], q[31:0]};
                    end
                end
`endif
                default: e = '0;
            endcase
        end else begin
            e.valid = 1'b1;
            case (ins[31:26])
                6'h04: begin e.out = a - b; e.taken = (a == b); end
                6'h05: begin e.out = a - b; e.taken = (a != b); end
                6'h08: begin r = sa + si; e.out = r[31:0]; e.ovf = !fits32(r); e.rw = 1'b1; end
                6'h09: begin e.out = a + simm; e.rw = 1'b1; end
                6'h0A: begin e.out = (sa < si) ? 32'd1 : 32'd0; e.rw = 1'b1; end
                6'h0B: begin e.out = (a < simm) ? 32'd1 : 32'd0; e.rw = 1'b1; end
                6'h0C: begin e.out = a & zimm; e.rw = 1'b1; end
                6'h0D: begin e.out = a | zimm; e.rw = 1'b1; end
                6'h0E: begin e.out = a ^ zimm; e.rw = 1'b1; end
                6'h23: begin e.out = a + simm; e.rw = 1'b1; e.m2r = 1'b1; end
                6'h2B: begin e.out = a + simm; e.mw = 1'b1; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    exp_t        cur;
    logic [31:0] pc_exp, hi_exp, lo_exp;
    logic [7:0]  flags_obs, flags_exp;
    assign cur       = model(i_datain, gr1, gr2);
    assign flags_obs = {overflow, zero, neg, pc_src, mem_write, reg_write, reg_dst, mem_to_reg};
    assign flags_exp = {cur.ovf, cur.valid && (cur.out == 32'h0), cur.out[31], cur.taken,
                        cur.mw, cur.rw, cur.rd, cur.m2r};

    // Architectural state scoreboard: next PC and HI/LO from the model's view of each instruction.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_exp <= 32'h0; hi_exp <= 32'h0; lo_exp <= 32'h0;
        end else begin
            pc_exp <= pc_exp + 32'd4 + (cur.taken ? {{14{i_datain[15]}}, i_datain[15:0], 2'b00} : 32'h0);
            if (cur.hl_we) {hi_exp, lo_exp} <= cur.hl;
        end
    end

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1 i_datain = 32'h014B4820; gr1 = 32'h8999_9999; gr2 = 32'h5DDD_DDDD;
        #1;
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo); end
        tests++; if (out !== 32'hE777_7776) begin fails++; $display("FAIL reset_comb_out: got %h want e7777776", out); end
        @(posedge clk); #1;
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_hold_pc: got %h want 00000000", pc); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_spec_vectors;
        logic [31:0] v_ins[8] = '{32'h014B4820, 32'h014B4822, 32'h014B4823, 32'h214B8000, 32'h314B0064,
                                  {6'h00, 5'd0, 5'd11, 5'd9, 5'd1, 6'h00}, {6'h00, 5'd0, 5'd11, 5'd9, 5'd10, 6'h03},
                                  {6'h00, 5'd10, 5'd11, 5'd9, 5'd0, 6'h04}};
        logic [31:0] v_out[8] = '{32'hE777_7776, 32'h2BBB_BBBC, 32'h2BBB_BBBC, 32'h8999_1999, 32'h0,
                                  32'hBBBB_BBBA, 32'h0017_7777, 32'hBA00_0000};
        logic        v_ovf[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); i_datain = v_ins[i]; gr1 = 32'h8999_9999; gr2 = 32'h5DDD_DDDD;
            #1;
            tests++; if (out !== v_out[i]) begin fails++; $display("FAIL vec%0d_out: got %h want %h", i, out, v_out[i]); end
            tests++; if (overflow !== v_ovf[i]) begin fails++; $display("FAIL vec%0d_ovf: got %b want %b", i, overflow, v_ovf[i]); end
            tests++; if (flags_obs !== flags_exp) begin fails++; $display("FAIL vec%0d_flags: got %b want %b", i, flags_obs, flags_exp); end
            if (i == 0) begin
                tests++; if ({neg, reg_dst, reg_write} !== 3'b111) begin fails++; $display("FAIL vec_add_ctrl: got %b want 111", {neg, reg_dst, reg_write}); end
            end
            if (i == 4) begin
                tests++; if (zero !== 1'b1) begin fails++; $display("FAIL vec_andi_zero: got %b want 1", zero); end
            end
        end
    endtask

    task automatic test_hilo;
        @(negedge clk); i_datain = {6'h00, 5'd10, 5'd11, 10'd0, 6'h18}; gr1 = 32'hFFFF_FFFE; gr2 = 32'd3;
        #1;
        tests++; if ({out, reg_write} !== 33'h0) begin fails++; $display("FAIL mult_out: got %h/%b want 0/0", out, reg_write); end
        @(posedge clk); #1;
        tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin fails++; $display("FAIL mult_hilo: got %h_%h want ffffffff_fffffffa", hi, lo); end
        @(negedge clk); i_datain = {6'h00, 5'd10, 5'd11, 10'd0, 6'h19};
        @(posedge clk); #1;
        tests++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin fails++; $display("FAIL multu_hilo: got %h_%h want 00000002_fffffffa", hi, lo); end
        @(negedge clk); i_datain = {6'h00, 5'd10, 5'd11, 10'd0, 6'h1B}; gr1 = 32'd7; gr2 = 32'd0;
        @(posedge clk); #1;
`ifdef ALU_DIVIDER_EN
        tests++; if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin fails++; $display("FAIL divu_zero: got %h_%h want 00000007_ffffffff", hi, lo); end
        @(negedge clk); i_datain = {6'h00, 5'd10, 5'd11, 10'd0, 6'h1A}; gr1 = 32'hFFFF_FFF9; gr2 = 32'd2;
        @(posedge clk); #1;
        tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin fails++; $display("FAIL div_signed: got %h_%h want ffffffff_fffffffd", hi, lo); end
`else
        tests++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin fails++; $display("FAIL divu_disabled: got %h_%h want 00000002_fffffffa", hi, lo); end
`endif
    endtask

    task automatic test_branch_pc;
        @(negedge clk); rst_n = 1'b0; #2 rst_n = 1'b1;
        i_datain = {6'h04, 5'd10, 5'd11, 16'hFFFF}; gr1 = 32'h1234; gr2 = 32'h1234;
        #1;
        tests++; if (pc_src !== 1'b1) begin fails++; $display("FAIL beq_taken: got %b want 1", pc_src); end
        @(posedge clk); #1;
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL beq_pc: got %h want 00000000", pc); end
        @(negedge clk); i_datain = {6'h05, 5'd10, 5'd11, 16'hFFFF};
        #1;
        tests++; if (pc_src !== 1'b0) begin fails++; $display("FAIL bne_taken: got %b want 0", pc_src); end
        @(posedge clk); #1;
        tests++; if (pc !== 32'h4) begin fails++; $display("FAIL bne_pc: got %h want 00000004", pc); end
    endtask

    task automatic test_unsupported;
        logic [31:0] bad[5] = '{{6'h3F, 26'h155_5555}, {6'h00, 20'hABCDE, 6'h01}, {6'h02, 26'h000_0040},
                                {6'h00, 20'h12345, 6'h3F}, {6'h00, 20'h0, 6'h1A}};
        int n;
`ifdef ALU_DIVIDER_EN
        n = 4;
`else
        n = 5;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk); i_datain = bad[i]; gr1 = $urandom; gr2 = $urandom;
            #1;
            tests++; if ({out, flags_obs, alu_ctrl} !== 44'h0) begin fails++; $display("FAIL unsup%0d_outputs: got out=%h flags=%b ctrl=%h want all 0", i, out, flags_obs, alu_ctrl); end
            @(posedge clk); #1;
            tests++; if ({hi, lo, pc} !== {hi_exp, lo_exp, pc_exp}) begin fails++; $display("FAIL unsup%0d_state: got %h_%h pc %h want %h_%h pc %h", i, hi, lo, pc, hi_exp, lo_exp, pc_exp); end
        end
    endtask

    task automatic test_random;
        logic [5:0] r_fn[20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h18, 6'h19, 6'h1A, 6'h1B};
        logic [5:0] i_op[11] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
        logic [31:0] ins, a, b;
        int sel;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) begin ins[31:26] = 6'h00; ins[5:0] = r_fn[$urandom_range(0, 19)]; end
            else ins[31:26] = i_op[$urandom_range(0, 10)];
            a = $urandom; b = $urandom; sel = $urandom_range(0, 9);
            if (sel < 2) b = a;
            else if (sel == 2) b = 32'h0;
            else if (sel == 3) begin a = {sel[0], 31'h7FFF_FFF0}; b = ~a + 32'd1; end
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            @(negedge clk); i_datain = ins; gr1 = a; gr2 = b;
            #1;
            tests++; if (out !== cur.out) begin fails++; $display("FAIL rnd%0d_out ins=%h: got %h want %h", i, ins, out, cur.out); end
            tests++; if (flags_obs !== flags_exp) begin fails++; $display("FAIL rnd%0d_flags ins=%h: got %b want %b", i, ins, flags_obs, flags_exp); end
            @(posedge clk); #1;
            tests++; if (pc !== pc_exp) begin fails++; $display("FAIL rnd%0d_pc: got %h want %h", i, pc, pc_exp); end
            tests++; if ({hi, lo} !== {hi_exp, lo_exp}) begin fails++; $display("FAIL rnd%0d_hilo: got %h_%h want %h_%h", i, hi, lo, hi_exp, lo_exp); end
        end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk); i_datain = {6'h00, 5'd10, 5'd11, 10'd0, 6'h19}; gr1 = 32'h1234_5678; gr2 = 32'h9ABC_DEF0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL midrun_pc: got %h want 00000000", pc); end
        tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL midrun_hilo: got %h_%h want 0", hi, lo); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; i_datain = 32'h0; gr1 = 32'h0; gr2 = 32'h0;
        test_reset;
        test_spec_vectors;
        test_hilo;
        test_branch_pc;
        test_unsupported;
        test_random;
        test_reset_midrun;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
